dma_cache_fill_ctrl: RTL and testbench

- Upstream stage of the DMA ping-pong cache. Consumes AXI4 read-data (R) beats for one descriptor chunk, realigns the byte stream from an arbitrary start offset, and writes packed cache words (wrEn/wrAddr/wrData/wrByteCnt).
- Owns rdCacheSel, which selects the cache being filled. Toggles it after each completed fill so the write-side initiator can drain the filled cache.

---
 rtl/dma_cache_fill_ctrl.sv | 210 +++++++++++++++++++++
 tb/tb_dma_cache_fill_ctrl.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/dma_cache_fill_ctrl.sv
// Fill side of the DMA ping-pong cache: takes AXI R beats for one chunk, realigns
// them from an arbitrary start byte and writes packed, zero-padded cache words.
module dma_cache_fill_ctrl #(
   parameter  int CACHE_WIDTH = 8,
   parameter  int CACHE_DEPTH = 16,
   localparam int OFS_W  = $clog2(CACHE_WIDTH),
   localparam int TBC_W  = $clog2(CACHE_WIDTH + 1),
   localparam int ADDR_W = (CACHE_DEPTH > 1) ? $clog2(CACHE_DEPTH) : 1,
   localparam int MBC_W  = $clog2(CACHE_DEPTH * CACHE_WIDTH + 1),
   localparam int DW     = CACHE_WIDTH * 8
) (
   input  logic              clock,
   input  logic              resetn,
   input  logic              cmdValid,
   output logic              cmdReady,
   input  logic [OFS_W-1:0]  cmdOffset,
   input  logic [MBC_W-1:0]  cmdByteCnt,
   input  logic              RVALID,
   output logic              RREADY,
   input  logic [DW-1:0]     RDATA,
   input  logic [1:0]        RRESP,
   input  logic              RLAST,
   input  logic [MBC_W-1:0]  fillCacheBytes,
   output logic              wrEn,
   output logic [ADDR_W-1:0] wrAddr,
   output logic [DW-1:0]     wrData,
   output logic [TBC_W-1:0]  wrByteCnt,
   output logic              rdCacheSel,
   output logic              fillDone,
   output logic              fillErr,
   output logic [2:0]        dbgState
);

   localparam int CNT_W = MBC_W + 1;
   localparam logic [MBC_W-1:0] MAX_BYTES = MBC_W'(CACHE_DEPTH * CACHE_WIDTH);

   typedef enum logic [2:0] {S_IDLE, S_WAIT_EMPTY, S_FILL, S_FLUSH, S_DONE} state_t;

   // Handshakes: a command is taken when cmdValid & cmdReady, an R beat when
   // RVALID & RREADY, both at the rising clock edge; both ready outputs are registered.
   state_t             state_q, state_d;
   logic [OFS_W-1:0]   off_q, off_d;
   logic [CNT_W-1:0]   exp_q, exp_d, out_q, out_d;
   logic [CNT_W-1:0]   beat_q, beat_d, word_q, word_d;
   logic [TBC_W-1:0]   last_bc_q, last_bc_d;
   logic [DW-1:0]      res_q, res_d;
   logic               err_q, err_d, zero_q, zero_d, sel_q, sel_d;
   logic               cmd_ready_q, rready_q, done_q, ferr_q;
   logic               wr_en_q, wr_en_d;
   logic [ADDR_W-1:0]  wr_addr_q, wr_addr_d;
   logic [DW-1:0]      wr_data_q, wr_data_d;
   logic [TBC_W-1:0]   wr_bc_q, wr_bc_d;

   logic               hs, take, is_last, emit;
   logic [DW-1:0]      fill_word, flush_word, emit_word;
   logic [TBC_W-1:0]   emit_bc, avail;

   // A word spans the residue (previous beat) and the current beat when offset != 0.
   assign fill_word  = DW'({RDATA, res_q} >> {off_q, 3'b000});
   assign flush_word = res_q >> {off_q, 3'b000};
   assign avail      = TBC_W'(CACHE_WIDTH) - TBC_W'(off_q);

   always_comb begin
      state_d   = state_q;
      off_d     = off_q;
      exp_d     = exp_q;
      out_d     = out_q;
      beat_d    = beat_q;
      word_d    = word_q;
      last_bc_d = last_bc_q;
      res_d     = res_q;
      err_d     = err_q;
      zero_d    = zero_q;
      sel_d     = sel_q;
      wr_en_d   = 1'b0;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      wr_bc_d   = wr_bc_q;
      emit      = 1'b0;
      emit_word = '0;
      emit_bc   = '0;
      hs        = rready_q & RVALID;
      take      = hs && (beat_q < exp_q);
      is_last   = (word_q == out_q - CNT_W'(1));

      unique case (state_q)
         S_IDLE: begin
            if (cmdValid && cmd_ready_q) begin
               off_d     = cmdOffset;
               exp_d     = (CNT_W'(cmdOffset) + CNT_W'(cmdByteCnt) + CNT_W'(CACHE_WIDTH - 1)) >> OFS_W;
               out_d     = (CNT_W'(cmdByteCnt) + CNT_W'(CACHE_WIDTH - 1)) >> OFS_W;
               last_bc_d = TBC_W'((cmdByteCnt - MBC_W'(1)) & MBC_W'(CACHE_WIDTH - 1)) + TBC_W'(1);
               beat_d    = '0;
               word_d    = '0;
               res_d     = '0;
               err_d     = 1'b0;
               zero_d    = (cmdByteCnt == '0);
               if (cmdByteCnt == '0) begin
                  state_d = S_DONE;
               end else if (cmdByteCnt > MAX_BYTES) begin
                  err_d   = 1'b1;
                  state_d = S_DONE;
               end else begin
                  state_d = S_WAIT_EMPTY;
               end
            end
         end
         S_WAIT_EMPTY: begin
            if (fillCacheBytes == '0) state_d = S_FILL;
         end
         S_FILL: begin
            if (hs && RRESP != 2'b00) err_d = 1'b1;
            if (take) begin
               beat_d = beat_q + CNT_W'(1);
               res_d  = RDATA;
               if ((off_q == '0 || beat_q != '0) && word_q < out_q) begin
                  emit      = 1'b1;
                  emit_word = (off_q == '0) ? RDATA : fill_word;
                  emit_bc   = is_last ? last_bc_q : TBC_W'(CACHE_WIDTH);
               end
               // Beats after the expected last one are discarded until RLAST shows up.
               if (!RLAST && beat_q + CNT_W'(1) == exp_q) err_d = 1'b1;
            end
            if (hs && RLAST) begin
               state_d = S_FLUSH;
               if (beat_q + CNT_W'(1) < exp_q) err_d = 1'b1;
            end
         end
         S_FLUSH: begin
            if (off_q != '0 && beat_q != '0 && word_q < out_q) begin
               emit      = 1'b1;
               emit_word = flush_word;
               emit_bc   = (is_last && last_bc_q < avail) ? last_bc_q : avail;
            end
            state_d = S_DONE;
         end
         S_DONE: begin
            state_d = S_IDLE;
            if (!err_q && !zero_q) sel_d = ~sel_q;
         end
         default: state_d = S_IDLE;
      endcase

      if (emit) begin
         wr_en_d   = 1'b1;
         wr_addr_d = word_q[ADDR_W-1:0];
         wr_bc_d   = emit_bc;
         word_d    = word_q + CNT_W'(1);
         for (int j = 0; j < CACHE_WIDTH; j++) begin
            wr_data_d[j*8 +: 8] = (j < int'(emit_bc)) ? emit_word[j*8 +: 8] : 8'h00;
         end
      end
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_q     <= S_IDLE;
         off_q       <= '0;
         exp_q       <= '0;
         out_q       <= '0;
         beat_q      <= '0;
         word_q      <= '0;
         last_bc_q   <= '0;
         res_q       <= '0;
         err_q       <= 1'b0;
         zero_q      <= 1'b0;
         sel_q       <= 1'b0;
         cmd_ready_q <= 1'b0;
         rready_q    <= 1'b0;
         done_q      <= 1'b0;
         ferr_q      <= 1'b0;
         wr_en_q     <= 1'b0;
         wr_addr_q   <= '0;
         wr_data_q   <= '0;
         wr_bc_q     <= '0;
      end else begin
         state_q     <= state_d;
         off_q       <= off_d;
         exp_q       <= exp_d;
         out_q       <= out_d;
         beat_q      <= beat_d;
         word_q      <= word_d;
         last_bc_q   <= last_bc_d;
         res_q       <= res_d;
         err_q       <= err_d;
         zero_q      <= zero_d;
         sel_q       <= sel_d;
         cmd_ready_q <= (state_d == S_IDLE);
         rready_q    <= (state_d == S_FILL);
         done_q      <= (state_d == S_DONE);
         ferr_q      <= (state_d == S_DONE) && err_d;
         wr_en_q     <= wr_en_d;
         wr_addr_q   <= wr_addr_d;
         wr_data_q   <= wr_data_d;
         wr_bc_q     <= wr_bc_d;
      end
   end

   assign cmdReady   = cmd_ready_q;
   assign RREADY     = rready_q;
   assign wrEn       = wr_en_q;
   assign wrAddr     = wr_addr_q;
   assign wrData     = wr_data_q;
   assign wrByteCnt  = wr_bc_q;
   assign rdCacheSel = sel_q;
   assign fillDone   = done_q;
   assign fillErr    = ferr_q;
   assign dbgState   = state_q;

endmodule

// File: tb/tb_dma_cache_fill_ctrl.sv
// Directed bench for dma_cache_fill_ctrl: hand-computed cache writes held in an
// expected queue and compared against writes captured from the DUT.
module tb_dma_cache_fill_ctrl;

   localparam int SBW = 4 + 4 + 64;

   logic        clock = 1'b0;
   logic        resetn;
   logic        cmdValid;
   logic        cmdReady;
   logic [2:0]  cmdOffset;
   logic [7:0]  cmdByteCnt;
   logic        RVALID;
   logic        RREADY;
   logic [63:0] RDATA;
   logic [1:0]  RRESP;
   logic        RLAST;
   logic [7:0]  fillCacheBytes;
   logic        wrEn;
   logic [3:0]  wrAddr;
   logic [63:0] wrData;
   logic [3:0]  wrByteCnt;
   logic        rdCacheSel;
   logic        fillDone;
   logic        fillErr;
   logic [2:0]  dbgState;

   int checks = 0;
   int errors = 0;
   int done_cnt = 0;
   int rready_cycles = 0;
   logic [SBW-1:0] exp_q[$];
   logic [SBW-1:0] wr_q[$];
   logic [63:0] pat [4];

   dma_cache_fill_ctrl #(.CACHE_WIDTH(8), .CACHE_DEPTH(16)) dut (
      .clock(clock), .resetn(resetn),
      .cmdValid(cmdValid), .cmdReady(cmdReady), .cmdOffset(cmdOffset), .cmdByteCnt(cmdByteCnt),
      .RVALID(RVALID), .RREADY(RREADY), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST),
      .fillCacheBytes(fillCacheBytes),
      .wrEn(wrEn), .wrAddr(wrAddr), .wrData(wrData), .wrByteCnt(wrByteCnt),
      .rdCacheSel(rdCacheSel), .fillDone(fillDone), .fillErr(fillErr), .dbgState(dbgState)
   );

   // clock / reset
   always #5 clock = ~clock;

   always @(negedge clock) begin
      if (wrEn) wr_q.push_back({wrAddr, wrByteCnt, wrData});
      if (fillDone) done_cnt++;
      if (RREADY) rready_cycles++;
   end

   task automatic check_eq(input string tag, input logic [SBW-1:0] obs, input logic [SBW-1:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // driver tasks
   task automatic send_cmd(input logic [2:0] off, input logic [7:0] cnt);
      cmdValid = 1'b1;
      cmdOffset = off;
      cmdByteCnt = cnt;
      for (int i = 0; i < 100 && !cmdReady; i++) @(negedge clock);
      check_eq("cmd_ready", SBW'(cmdReady), SBW'(1));
      @(negedge clock);
      cmdValid = 1'b0;
   endtask

   task automatic send_beat(input logic [63:0] data, input logic [1:0] resp, input logic last);
      RVALID = 1'b1;
      RDATA = data;
      RRESP = resp;
      RLAST = last;
      for (int i = 0; i < 100 && !RREADY; i++) @(negedge clock);
      check_eq("rready", SBW'(RREADY), SBW'(1));
      @(negedge clock);
      RVALID = 1'b0;
      RLAST = 1'b0;
      RRESP = 2'b00;
   endtask

   task automatic exp_push(input logic [3:0] addr, input logic [3:0] bc, input logic [63:0] data);
      exp_q.push_back({addr, bc, data});
   endtask

   // scoreboard
   task automatic finish_fill(input string tag, input logic exp_err, input logic exp_sel);
      for (int i = 0; i < 100 && !fillDone; i++) @(negedge clock);
      check_eq({tag, "_done"}, SBW'(fillDone), SBW'(1));
      check_eq({tag, "_err"}, SBW'(fillErr), SBW'(exp_err));
      @(negedge clock);
      check_eq({tag, "_pulse"}, SBW'(fillDone), SBW'(0));
      check_eq({tag, "_sel"}, SBW'(rdCacheSel), SBW'(exp_sel));
      check_eq({tag, "_nwr"}, SBW'(wr_q.size()), SBW'(exp_q.size()));
      while (wr_q.size() > 0 && exp_q.size() > 0) begin
         check_eq({tag, "_wr"}, wr_q.pop_front(), exp_q.pop_front());
      end
      wr_q.delete();
      exp_q.delete();
   endtask

   initial begin
      int base;
      pat[0] = 64'h0123456789abcdef;
      pat[1] = 64'hfedcba9876543210;
      pat[2] = 64'h1122334455667788;
      pat[3] = 64'h99aabbccddeeff00;
      resetn = 1'b0;
      cmdValid = 1'b0; cmdOffset = '0; cmdByteCnt = '0;
      RVALID = 1'b0; RDATA = '0; RRESP = '0; RLAST = 1'b0;
      fillCacheBytes = '0;
      repeat (3) @(negedge clock);
      check_eq("rst_outs", SBW'({cmdReady, RREADY, wrEn, wrAddr, wrData, wrByteCnt,
                                 rdCacheSel, fillDone, fillErr, dbgState}), SBW'(0));
      resetn = 1'b1;
      @(negedge clock);

      // aligned fill, 4 beats
      send_cmd(3'd0, 8'd32);
      for (int k = 0; k < 4; k++) begin
         send_beat(pat[k], 2'b00, k == 3);
         exp_push(4'(k), 4'd8, pat[k]);
      end
      finish_fill("aligned", 1'b0, 1'b1);

      // unaligned fill, offset 3, 13 bytes, byte i = i
      send_cmd(3'd3, 8'd13);
      send_beat(64'h0706050403020100, 2'b00, 1'b0);
      send_beat(64'h0f0e0d0c0b0a0908, 2'b00, 1'b1);
      check_eq("unal_flush_rready", SBW'(RREADY), SBW'(0));
      exp_push(4'd0, 4'd8, 64'h0a09080706050403);
      exp_push(4'd1, 4'd5, 64'h0000000f0e0d0c0b);
      finish_fill("unaligned", 1'b0, 1'b0);

      // cache not yet drained
      fillCacheBytes = 8'd24;
      send_cmd(3'd0, 8'd8);
      check_eq("bp_rready0", SBW'(RREADY), SBW'(0));
      repeat (4) @(negedge clock);
      check_eq("bp_rready1", SBW'(RREADY), SBW'(0));
      fillCacheBytes = 8'd0;
      check_eq("bp_rready2", SBW'(RREADY), SBW'(0));
      @(negedge clock);
      check_eq("bp_rready3", SBW'(RREADY), SBW'(1));
      send_beat(64'hdeadbeefcafef00d, 2'b00, 1'b1);
      exp_push(4'd0, 4'd8, 64'hdeadbeefcafef00d);
      finish_fill("backpressure", 1'b0, 1'b1);

      // SLVERR on beat 2 still writes everything
      send_cmd(3'd0, 8'd32);
      for (int k = 0; k < 4; k++) begin
         send_beat(pat[k], (k == 1) ? 2'b10 : 2'b00, k == 3);
         exp_push(4'(k), 4'd8, pat[k]);
      end
      finish_fill("rresp", 1'b1, 1'b1);

      // zero-byte command
      send_cmd(3'd0, 8'd0);
      check_eq("zero_done_now", SBW'(fillDone), SBW'(1));
      finish_fill("zero", 1'b0, 1'b1);

      // oversized command
      base = rready_cycles;
      send_cmd(3'd0, 8'd129);
      check_eq("big_done_now", SBW'(fillDone), SBW'(1));
      finish_fill("oversize", 1'b1, 1'b1);
      check_eq("big_no_rready", SBW'(rready_cycles), SBW'(base));

      // RLAST on beat 2 of 3
      send_cmd(3'd0, 8'd24);
      send_beat(pat[0], 2'b00, 1'b0);
      send_beat(pat[1], 2'b00, 1'b1);
      exp_push(4'd0, 4'd8, pat[0]);
      exp_push(4'd1, 4'd8, pat[1]);
      finish_fill("early_last", 1'b1, 1'b1);

      // RLAST missing on the single expected beat: extra beat discarded
      send_cmd(3'd0, 8'd8);
      send_beat(pat[2], 2'b00, 1'b0);
      check_eq("late_rready_held", SBW'(RREADY), SBW'(1));
      send_beat(pat[3], 2'b00, 1'b1);
      exp_push(4'd0, 4'd8, pat[2]);
      finish_fill("late_last", 1'b1, 1'b1);

      // asynchronous reset in the middle of a fill
      send_cmd(3'd0, 8'd16);
      send_beat(pat[3], 2'b00, 1'b0);
      check_eq("mid_wren", SBW'(wrEn), SBW'(1));
      base = done_cnt;
      #2 resetn = 1'b0;
      #1 check_eq("async_rst_outs", SBW'({cmdReady, RREADY, wrEn, wrAddr, wrData, wrByteCnt,
                                          rdCacheSel, fillDone, fillErr, dbgState}), SBW'(0));
      @(negedge clock);
      resetn = 1'b1;
      repeat (5) @(negedge clock);
      check_eq("rst_no_done", SBW'(done_cnt), SBW'(base));
      check_eq("rst_cmd_ready", SBW'(cmdReady), SBW'(1));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
